// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: phase state encoding,
// the halting opcode and the width of the cycle/instruction counters.
package phase_sequencer_pkg;

  // Width of both free-running counters.
  localparam int CNT_W = 16;

  // Opcode that halts the sequencer once its instruction completes.
  localparam logic [3:0] OP_STP = 4'b0111;

  // Raw state codes, kept as plain constants for tools that want them.
  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC1 = 2'd2;
  localparam logic [1:0] ST_EXEC2 = 2'd3;

  typedef enum logic [1:0] {
    HALT    = ST_HALT,
    S_FETCH = ST_FETCH,
    S_EXEC1 = ST_EXEC1,
    S_EXEC2 = ST_EXEC2
  } state_t;

  // True when the opcode is the halt instruction.
  function automatic logic is_stp(input logic [3:0] op);
    return (op == OP_STP);
  endfunction

endpackage

// File: rtl/phase_sequencer_wrap_counter.sv
// Wrapping up-counter with a synchronous clear that beats the increment.
module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; otherwise count up and roll over naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks FETCH -> EXEC1 -> (EXEC2) per
// instruction, stalling on memory, with run / single-step / stop control
// and cycle and instruction counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HALT    | idle; waits for START (free run) or STEP (one instruction)
//   S_FETCH | fetching the opcode; completes on MEM_READY
//   S_EXEC1 | first execute phase; EXTRA selects EXEC2 or completion
//   S_EXEC2 | second execute phase; always completes the instruction
module phase_sequencer
  import phase_sequencer_pkg::*;
(
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             START,
  input  logic             STEP,
  input  logic             STOP,
  input  logic             MEM_READY,
  input  logic             EXTRA,
  input  logic [3:0]       IR,
  input  logic             CLR_CNT,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             IR_LOAD,
  output logic             WAIT,
  output logic             HALTED,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_t state_q;
  state_t state_d;
  logic   step_q;
  logic   step_d;
  logic   stop_pend_q;
  logic   stop_pend_d;

  logic in_halt;
  logic launch;
  logic complete;
  logic halt_req;

  assign in_halt = (state_q == HALT);

  // A simultaneous STOP cancels a START/STEP issued from HALT.
  assign launch = in_halt && (START || STEP) && !STOP;

  // Phase strobes are only high in the cycle the phase actually finishes.
  always_comb begin
    FETCH = (state_q == S_FETCH) && MEM_READY;
    EXEC1 = (state_q == S_EXEC1) && MEM_READY;
    EXEC2 = (state_q == S_EXEC2) && MEM_READY;
    WAIT  = !in_halt && !MEM_READY;
  end

  assign IR_LOAD = FETCH;
  assign HALTED  = in_halt;

  assign complete = (EXEC1 && !EXTRA) || EXEC2;

  // A STOP arriving in the completion cycle itself is honoured at this boundary.
  assign halt_req = is_stp(IR) || step_q || stop_pend_q || STOP;

  // Next-state selection; phases hold while memory is not ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (launch) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (MEM_READY) state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (MEM_READY) begin
          if (EXTRA)         state_d = S_EXEC2;
          else if (halt_req) state_d = HALT;
          else               state_d = S_FETCH;
        end
      end
      S_EXEC2: begin
        if (MEM_READY) begin
          if (halt_req) state_d = HALT;
          else          state_d = S_FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Single-step mode is latched at launch; STEP wins if both pulses coincide.
  // Pending stop is set outside HALT and dropped on the way back into HALT.
  always_comb begin
    step_d      = step_q;
    stop_pend_d = stop_pend_q;
    if (launch) step_d = STEP;
    if (!in_halt && STOP) stop_pend_d = 1'b1;
    if (!in_halt && (state_d == HALT)) stop_pend_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= HALT;
      step_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  wrap_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (CLK),
    .rst_n (nRESET),
    .clr   (CLR_CNT),
    .inc   (!in_halt),
    .count (CYCLE_CNT)
  );

  wrap_counter #(.WIDTH(CNT_W)) u_instr_cnt (
    .clk   (CLK),
    .rst_n (nRESET),
    .clr   (CLR_CNT),
    .inc   (complete),
    .count (INSTR_CNT)
  );

endmodule
